// File: rtl/spmv_result_packer_if.sv
// Result-packer bus bundle.
//   Beat side : valid_in (beat strobe), lane_in (8 x 16-bit signed lanes), relu_en.
//   BRAM side : bram_en, bram_we, bram_addr (AW bits), bram_din (PACK*64 bits).
// slave  = the packer (consumes beats, drives the BRAM write port).
// master = the upstream/BRAM side (drives beats, observes the BRAM writes).
interface spmv_result_packer_if #(
  parameter int PACK = 4,
  parameter int AW   = 8
) ();
  logic                 valid_in;
  logic [127:0]         lane_in;
  logic                 relu_en;
  logic                 bram_en;
  logic                 bram_we;
  logic [AW-1:0]        bram_addr;
  logic [PACK*64-1:0]   bram_din;

  modport slave (
    input  valid_in, lane_in, relu_en,
    output bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output valid_in, lane_in, relu_en,
    input  bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/spmv_result_packer.sv
// Sparse MxV result packer. Each accepted beat of 8 signed 16-bit lanes is shifted,
// optionally ReLU-clamped and saturated to 8 bits (stage 1), then packed PACK beats
// per BRAM word (stage 2) and written to the activation BRAM at word addresses
// 0,1,2,... per run.
// Ports:
//   clk       clock
//   rst       synchronous, active-low reset
//   idle      level; while high clears the block and arms it for a new run
//   bus       beat input and BRAM write port (slave side)
//   done      high from end of last write until idle or reset
//   overflow  sticky; a beat arrived outside the ARMED/RUN window
//
// state  | meaning
// IDLE   | after reset; beats are rejected and flag overflow
// ARMED  | cleared by idle; first beat starts the run
// RUN    | accepting beats until beat NUM_BEATS-1
// FLUSH  | 2 cycles: drain the pipeline, write a trailing partial word
// DONE   | run complete; beats are rejected and flag overflow
module spmv_result_packer #(
  parameter int NUM_BEATS = 1024,
  parameter int PACK      = 4,
  parameter int SHIFT     = 4,
  parameter int AW        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idle,
  spmv_result_packer_if.slave      bus,
  output logic                     done,
  output logic                     overflow
);
  localparam int DW = PACK * 64;
  localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BW = $clog2(NUM_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [SW-1:0]   slot_cnt;
  logic [AW-1:0]   word_cnt;
  logic            flush_cnt;
  logic [DW-1:0]   pack_reg;
  logic            s1_valid;
  logic [63:0]     s1_data;
  logic [63:0]     lane_y;
  logic [DW-1:0]   next_word;
  logic            accept;

  function automatic logic [7:0] lane_fn(input logic [15:0] lane, input logic relu);
    logic signed [15:0] y;
    y = $signed(lane) >>> SHIFT;
    if (relu && (y < 16'sd0)) y = 16'sd0;
    if (y > 16'sd127)       return 8'h7f;
    else if (y < -16'sd128) return 8'h80;
    else                    return y[7:0];
  endfunction

  always_comb begin
    lane_y = '0;
    for (int k = 0; k < 8; k++)
      lane_y[8*k +: 8] = lane_fn(bus.lane_in[16*k +: 16], bus.relu_en);
  end

  // Pack register with the stage-1 beat dropped into its slot; this is also the
  // full word written when the slot is the last one.
  always_comb begin
    next_word = pack_reg;
    next_word[int'(slot_cnt)*64 +: 64] = s1_data;
  end

  assign accept = bus.valid_in && ((state == S_ARMED) || (state == S_RUN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      beat_cnt      <= '0;
      slot_cnt      <= '0;
      word_cnt      <= '0;
      flush_cnt     <= 1'b0;
      pack_reg      <= '0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else if (idle) begin
      state         <= S_ARMED;
      beat_cnt      <= '0;
      slot_cnt      <= '0;
      word_cnt      <= '0;
      flush_cnt     <= 1'b0;
      pack_reg      <= '0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      bus.bram_en <= 1'b0;
      bus.bram_we <= 1'b0;
      s1_valid    <= accept;
      if (accept) s1_data <= lane_y;
      if (bus.valid_in && !accept) overflow <= 1'b1;

      if (s1_valid) begin
        if (slot_cnt == SW'(PACK - 1)) begin
          bus.bram_en   <= 1'b1;
          bus.bram_we   <= 1'b1;
          bus.bram_addr <= word_cnt;
          bus.bram_din  <= next_word;
          word_cnt      <= word_cnt + 1'b1;
          pack_reg      <= '0;
          slot_cnt      <= '0;
        end else begin
          pack_reg <= next_word;
          slot_cnt <= slot_cnt + 1'b1;
        end
      end

      case (state)
        S_ARMED, S_RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BW'(NUM_BEATS - 1)) begin
              state     <= S_FLUSH;
              flush_cnt <= 1'b0;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_FLUSH: begin
          // First cycle lets the last beat land in the pack reg; the second
          // writes whatever partial word remains (upper slots are still zero).
          if (!flush_cnt) begin
            flush_cnt <= 1'b1;
          end else begin
            if (slot_cnt != '0) begin
              bus.bram_en   <= 1'b1;
              bus.bram_we   <= 1'b1;
              bus.bram_addr <= word_cnt;
              bus.bram_din  <= pack_reg;
              word_cnt      <= word_cnt + 1'b1;
              pack_reg      <= '0;
              slot_cnt      <= '0;
            end
            state <= S_DONE;
            done  <= (slot_cnt == '0);
          end
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
